// File: rtl/coin_credit_unit.sv
// coin_credit_unit: synchronised button edges, credit accumulation and vend/refund FSM with a timed change hold.
module coin_credit_unit #(
  parameter int CREDIT_W    = 5,
  parameter int MAX_CREDIT  = 31,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                CLOCK_50,
  input  logic                RST,
  input  logic [3:0]          COIN_IN,
  input  logic                BUY,
  input  logic                CANCEL,
  input  logic [CREDIT_W-1:0] PRICE,
  output logic [CREDIT_W-1:0] CREDIT,
  output logic [CREDIT_W-1:0] CHANGE,
  output logic                VEND,
  output logic                REFUND,
  output logic                DENY,
  output logic                REJECT,
  output logic                BUSY,
  output logic [1:0]          STATE
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  typedef enum logic [1:0] {IDLE = 2'b00, CREDITED = 2'b01, HOLD = 2'b10} state_t;
  state_t state, state_n;
  logic [5:0] s1, s2, prev, edges;
  logic [3:0] coin;
  logic buy_e, cancel_e, one_coin, coin_ok, afford;
  logic [CREDIT_W-1:0] val, credit_n, change_n;
  logic [CREDIT_W:0] sum;
  logic [CW-1:0] cnt, cnt_n;
  logic vend_n, refund_n, deny_n, reject_n;
  assign edges    = s2 & ~prev;
  assign coin     = edges[3:0];
  assign buy_e    = edges[4];
  assign cancel_e = edges[5];
  assign val      = coin[3] ? CREDIT_W'(10) : coin[2] ? CREDIT_W'(5) : coin[1] ? CREDIT_W'(2) : CREDIT_W'(1);
  // One extra bit keeps an overflowing sum from wrapping below MAX_CREDIT.
  assign sum      = {1'b0, CREDIT} + {1'b0, val};
  assign one_coin = (coin != 4'd0) && ((coin & (coin - 4'd1)) == 4'd0);
  assign coin_ok  = one_coin && (sum <= (CREDIT_W + 1)'(MAX_CREDIT));
  assign afford   = (PRICE != '0) && (CREDIT >= PRICE);
  assign BUSY     = (state == HOLD);
  assign STATE    = state;
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      s1     <= '0;
      s2     <= '0;
      prev   <= '0;
      state  <= IDLE;
      CREDIT <= '0;
      CHANGE <= '0;
      cnt    <= '0;
      VEND   <= 1'b0;
      REFUND <= 1'b0;
      DENY   <= 1'b0;
      REJECT <= 1'b0;
    end else begin
      s1     <= {CANCEL, BUY, COIN_IN};
      s2     <= s1;
      prev   <= s2;
      state  <= state_n;
      CREDIT <= credit_n;
      CHANGE <= change_n;
      cnt    <= cnt_n;
      VEND   <= vend_n;
      REFUND <= refund_n;
      DENY   <= deny_n;
      REJECT <= reject_n;
    end
  end
  always_comb begin
    state_n  = state;
    credit_n = CREDIT;
    change_n = CHANGE;
    cnt_n    = cnt;
    vend_n   = 1'b0;
    refund_n = 1'b0;
    deny_n   = 1'b0;
    reject_n = 1'b0;
    if (state == HOLD) begin
      reject_n = |coin;
      if (cnt == CW'(HOLD_CYCLES - 1)) begin
        state_n  = IDLE;
        change_n = '0;
        cnt_n    = '0;
      end else cnt_n = cnt + CW'(1);
    end else if (cancel_e && state == CREDITED) begin
      refund_n = 1'b1;
      reject_n = |coin;
      change_n = CREDIT;
      credit_n = '0;
      cnt_n    = '0;
      state_n  = HOLD;
    end else if (buy_e) begin
      reject_n = |coin;
      if (afford) begin
        vend_n   = 1'b1;
        change_n = CREDIT - PRICE;
        credit_n = '0;
        cnt_n    = '0;
        state_n  = HOLD;
      end else deny_n = 1'b1;
    end else if (|coin) begin
      if (coin_ok) begin
        credit_n = sum[CREDIT_W-1:0];
        state_n  = CREDITED;
      end else reject_n = 1'b1;
    end
  end
endmodule
